// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the 7-segment display path
package seg7_pkg;

  localparam int SEG7_MAX_DIGITS = 8;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - time-multiplexed anode scanner for a common-anode 7-segment display
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              data,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  scan_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  capture, slot_end;
  bcd_t                  sel_digit;
  logic                  sel_en, sel_dp;
  logic [NUM_DIGITS-1:0] an_mask;

  assign slot_end = (cnt == CNT_LAST);
  assign capture  = (state_q == BLANK) && (cnt == BLANK_END);

  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   if (cnt == BLANK_END) state_d = SHOW;
      SHOW:    if (slot_end)         state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  // Mux the current digit's fields and build its anode pattern without shifts.
  always_comb begin
    sel_digit = 4'h0;
    sel_en    = 1'b0;
    sel_dp    = 1'b0;
    an_mask   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_digit  = digits[4*i +: 4];
        sel_en     = digit_en[i];
        sel_dp     = dp_in[i];
        an_mask[i] = ~digit_en[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      data       <= 4'h0;
      an         <= '1;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (slot_end) begin
        cnt        <= '0;
        an         <= '1;
        dp         <= 1'b1;
        idx        <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        frame_tick <= (idx == IDX_LAST);
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Slot outputs are frozen here so mid-slot input changes wait for the next slot.
      if (capture) begin
        data <= sel_digit;
        an   <= an_mask;
        dp   <= ~(sel_dp & sel_en);
      end
    end
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed scanner for an N-digit common-anode 7-segment display. Each refresh slot selects one digit, drives its 4-bit BCD value to the downstream `Hex7Seg` decoder, and asserts that digit's active-low anode. A blanking gap at the start of every slot suppresses ghosting. Sits between the clock/counter logic that produces BCD digits and the `Hex7Seg` decoder feeding the board's segment pins.

## Interface
- `NUM_DIGITS`, default 8: digits scanned; range 2..8.
- `REFRESH_DIV`, default 100000: clock cycles per digit slot; must be greater than `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 1000: cycles at slot start with all anodes off; must be at least 1.
- Reset is asynchronous and active-low; the block uses a single clock.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `digits`  in  4*NUM_DIGITS  BCD digit i at [4i+3:4i]; digit 0 is rightmost.
- `digit_en`  in  NUM_DIGITS  1 = digit i lit; 0 = anode held off for its slot.
- `dp_in`  in  NUM_DIGITS  1 = decimal point of digit i on.
- `data`  out  4  BCD value to `Hex7Seg.data`.
- `an`  out  NUM_DIGITS  anode enables, active-low, one-hot-zero.
- `dp`  out  1  decimal point segment, active-low.
- `frame_tick`  out  1  one-cycle pulse when the scan index wraps to 0.

## Operation
- State: `BLANK`/`SHOW` FSM, slot counter `cnt` (0..REFRESH_DIV-1), digit index `idx` (0..NUM_DIGITS-1).
- `BLANK`: `an` all ones, `dp` = 1, `data` holds its last value. When `cnt == BLANK_CYCLES-1`, go to `SHOW` and capture `digits[idx]`, `digit_en[idx]` and `dp_in[idx]` into output registers.
- `SHOW`: `an[idx] = ~captured_en`, all other anode bits 1; `data` = captured digit; `dp = ~(captured_dp & captured_en)`. These values are frozen for the whole slot, so input changes mid-slot have no effect until the next slot.
- When `cnt == REFRESH_DIV-1`:
  - `cnt` goes to 0, state goes to `BLANK`, and `idx` advances by 1.
  - `idx` wraps from NUM_DIGITS-1 to 0, and `frame_tick` pulses for 1 cycle together with that wrap.
- Digits with `digit_en = 0` still consume their full slot time, so brightness of the other digits stays uniform.
- Values 10..15 on a digit pass through unchanged; the decoder renders them as 0.
- Reset asserted at any time returns to the reset state immediately (asynchronous). There is no partial slot completion.

## Timing
- Reset values: state `BLANK`, `cnt` 0, `idx` 0, `data` 4'h0, `an` all ones, `dp` 1, `frame_tick` 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- After `rst_n` deasserts, cycles 0..BLANK_CYCLES-1 are blank. `an[0]` goes low at cycle BLANK_CYCLES, showing `digits[3:0]` as sampled on the edge ending cycle BLANK_CYCLES-1.
- Slot k spans cycles k·REFRESH_DIV .. (k+1)·REFRESH_DIV-1.
- A full frame is NUM_DIGITS·REFRESH_DIV cycles. `frame_tick` is high during cycle NUM_DIGITS·REFRESH_DIV, then recurs at the same period.
- `an` never has more than one bit low. Any two consecutive lit slots are separated by at least BLANK_CYCLES cycles of all-ones `an`.

## Structure
- Shared package `seg7_pkg`:
  - `scan_state_t` enum (`BLANK`, `SHOW`).
  - Constant `SEG7_MAX_DIGITS = 8`.
  - `bcd_t` typedef (logic [3:0]), also usable by the counter stages.
- No sub-module is needed; counter, FSM and output registers are inline.
- `Hex7Seg` is instantiated by the parent, not inside this block.

## Test plan
Directed scenarios, all using `NUM_DIGITS=4`, `REFRESH_DIV=8`, `BLANK_CYCLES=2`:
- **Reset:** hold `rst_n` = 0 → `an` = 4'b1111, `dp` = 1, `data` = 0, `frame_tick` = 0. Release → `an` = 4'b1110 exactly at cycle 2 with `data` = `digits[3:0]`.
- **Scan order:** `digits` = 16'h4321, all enabled → `data` sequence 1, 2, 3, 4 with `an` = 1110, 1101, 1011, 0111. Each value is held 6 cycles and separated by 2 cycles of 1111. `frame_tick` pulses at cycle 32 and again at 64.
- **Enable mask:** `digit_en` = 4'b0101 → slots 1 and 3 keep `an` = 1111 for all 8 cycles, and `frame_tick` timing is unchanged.
- **Mid-slot change:** change `digits[3:0]` from 1 to 9 during the `SHOW` phase of slot 0 → `data` stays 1 until the slot ends, and shows 9 in the next frame's slot 0.
- **Decimal point:** `dp_in` = 4'b0010 → `dp` = 0 only during `SHOW` of slot 1. With `digit_en[1]` = 0, `dp` stays 1.
- **Reset mid-operation:** assert `rst_n` low during slot 2 `SHOW` → same-cycle asynchronous return to reset values. Release → scanning restarts from digit 0 with the 2-cycle blank.
